// File: rtl/can_pkg.sv
// Shared CAN definitions: field widths, CRC-15 polynomial, receiver states and error codes.
package can_pkg;

   localparam logic [14:0] CRC15_POLY  = 15'h4599;
   localparam int          ID_W        = 11;
   localparam int          DLC_W       = 4;
   localparam int          DATA_W      = 64;
   localparam int          CRC_W       = 15;
   localparam int          STUFF_LIMIT = 5;
   localparam int          HDR_BITS    = ID_W + 3 + DLC_W;

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      CRC_DELIM,
      WAIT_IDLE
   } rx_state_t;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_STUFF = 2'b01;
   localparam logic [1:0] ERR_FORM  = 2'b10;

   // One serial step of the CAN CRC-15 register; shared by receiver and transmitter.
   function automatic logic [CRC_W-1:0] crc15_step(input logic [CRC_W-1:0] c, input logic b);
      logic [CRC_W-1:0] s;
      s = {c[CRC_W-2:0], 1'b0};
      if ((b ^ c[CRC_W-1]) == 1'b1) begin
         s = s ^ CRC15_POLY;
      end
      return s;
   endfunction

endpackage

// File: rtl/can_rx_if.sv
// Receiver-side bus bundle: the serial CAN line in, decoded frame and status out.
interface can_rx_if;
   import can_pkg::*;

   logic              rx;
   logic              busy;
   logic              rx_valid;
   logic [ID_W-1:0]   rx_id;
   logic [DLC_W-1:0]  rx_dlc;
   logic [DATA_W-1:0] rx_data;
   logic [CRC_W-1:0]  rx_crc;
   logic              rx_crc_err;
   logic              rx_err;
   logic [1:0]        rx_err_code;

   modport master (
      output rx,
      input  busy, rx_valid, rx_id, rx_dlc, rx_data, rx_crc, rx_crc_err, rx_err, rx_err_code
   );

   modport slave (
      input  rx,
      output busy, rx_valid, rx_id, rx_dlc, rx_data, rx_crc, rx_crc_err, rx_err, rx_err_code
   );

endinterface

// File: rtl/can_crc15.sv
// Serial CAN CRC-15 accumulator, one bit per enabled clock; clear has priority over en.
module can_crc15
   import can_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             en,
   input  logic             bit_in,
   output logic [CRC_W-1:0] crc
);

   logic [CRC_W-1:0] r_crc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_crc <= '0;
      end else if (clear) begin
         r_crc <= '0;
      end else if (en) begin
         r_crc <= crc15_step(r_crc, bit_in);
      end
   end

   assign crc = r_crc;

endmodule

// File: rtl/can_rx.sv
// CAN 2.0A base-frame receiver at one bit per clock: destuffs SOF..CRC, assembles
// the fields, checks the CRC delimiter and CRC-15, then waits for bus idle.
module can_rx
   import can_pkg::*;
#(
   parameter int IDLE_BITS = 3,
   parameter bit CRC_EN    = 1'b1
) (
   input logic     clk,
   input logic     rst_n,
   can_rx_if.slave bus
);

   localparam int            IW        = $clog2(IDLE_BITS + 1);
   localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_BITS - 1);

   logic              r_rxMeta, r_rxSync;
   rx_state_t         r_state, w_nextState;
   logic [6:0]        r_bitCnt;
   logic              r_lastBit;
   logic [2:0]        r_sameCnt;
   logic [ID_W-1:0]   r_id;
   logic [DLC_W-1:0]  r_dlc;
   logic [DATA_W-1:0] r_data;
   logic [CRC_W-1:0]  r_crcRx;
   logic [IW-1:0]     r_idleCnt;

   logic              r_valid, r_err, r_crcErr;
   logic [1:0]        r_errCode;
   logic [ID_W-1:0]   r_outId;
   logic [DLC_W-1:0]  r_outDlc;
   logic [DATA_W-1:0] r_outData;
   logic [CRC_W-1:0]  r_outCrc;

   logic              w_bit, w_stuffPos, w_crcEn;
   logic              w_sof, w_take, w_stuffErr, w_formErr, w_frameOk;
   logic [3:0]        w_dataBytes;
   logic [6:0]        w_dataEnd, w_crcLast;
   logic [5:0]        w_dataIdx, w_dataPos;
   logic [CRC_W-1:0]  w_crc;

   assign w_bit       = r_rxSync;
   assign w_stuffPos  = (r_sameCnt == 3'(STUFF_LIMIT));
   assign w_dataBytes = (r_dlc > 4'd8) ? 4'd8 : r_dlc;
   assign w_dataEnd   = 7'(HDR_BITS) + {w_dataBytes, 3'b000};
   assign w_crcLast   = w_dataEnd + 7'(CRC_W - 1);
   // Byte k of the payload lands in [8k+7:8k] with its first-received bit at the top.
   assign w_dataIdx   = 6'(r_bitCnt - 7'(HDR_BITS));
   assign w_dataPos   = {w_dataIdx[5:3], ~w_dataIdx[2:0]};
   assign w_crcEn     = w_take && (r_bitCnt < w_dataEnd);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rxMeta <= 1'b1;
         r_rxSync <= 1'b1;
         r_state  <= IDLE;
      end else begin
         r_rxMeta <= bus.rx;
         r_rxSync <= r_rxMeta;
         r_state  <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_sof       = 1'b0;
      w_take      = 1'b0;
      w_stuffErr  = 1'b0;
      w_formErr   = 1'b0;
      w_frameOk   = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_bit) begin
               w_sof       = 1'b1;
               w_nextState = RECV;
            end
         end
         RECV: begin
            if (w_stuffPos) begin
               if (w_bit == r_lastBit) begin
                  w_stuffErr  = 1'b1;
                  w_nextState = WAIT_IDLE;
               end
            end else begin
               w_take = 1'b1;
               if (r_bitCnt == w_crcLast) begin
                  w_nextState = CRC_DELIM;
               end
            end
         end
         CRC_DELIM: begin
            w_frameOk   = w_bit;
            w_formErr   = ~w_bit;
            w_nextState = WAIT_IDLE;
         end
         WAIT_IDLE: begin
            if (w_bit && (r_idleCnt == IDLE_LAST)) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bitCnt  <= '0;
         r_lastBit <= 1'b0;
         r_sameCnt <= '0;
         r_id      <= '0;
         r_dlc     <= '0;
         r_data    <= '0;
         r_crcRx   <= '0;
      end else if (w_sof) begin
         r_bitCnt  <= '0;
         r_lastBit <= 1'b0;
         r_sameCnt <= 3'd1;
         r_id      <= '0;
         r_dlc     <= '0;
         r_data    <= '0;
         r_crcRx   <= '0;
      end else if (r_state == RECV) begin
         if (w_stuffPos) begin
            r_lastBit <= w_bit;
            r_sameCnt <= 3'd1;
         end else begin
            r_sameCnt <= (w_bit == r_lastBit) ? r_sameCnt + 3'd1 : 3'd1;
            r_lastBit <= w_bit;
            r_bitCnt  <= r_bitCnt + 7'd1;
            if (r_bitCnt < 7'(ID_W)) begin
               r_id <= {r_id[ID_W-2:0], w_bit};
            end else if (r_bitCnt < 7'(HDR_BITS - DLC_W)) begin
               r_id <= r_id;
            end else if (r_bitCnt < 7'(HDR_BITS)) begin
               r_dlc <= {r_dlc[DLC_W-2:0], w_bit};
            end else if (r_bitCnt < w_dataEnd) begin
               r_data[w_dataPos] <= w_bit;
            end else begin
               r_crcRx <= {r_crcRx[CRC_W-2:0], w_bit};
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_idleCnt <= '0;
      end else if ((r_state != WAIT_IDLE) || !w_bit) begin
         r_idleCnt <= '0;
      end else begin
         r_idleCnt <= r_idleCnt + 1'b1;
      end
   end

   // Decoded fields only move on a good frame so they hold across errors.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid   <= 1'b0;
         r_err     <= 1'b0;
         r_errCode <= ERR_NONE;
         r_crcErr  <= 1'b0;
         r_outId   <= '0;
         r_outDlc  <= '0;
         r_outData <= '0;
         r_outCrc  <= '0;
      end else begin
         r_valid <= w_frameOk;
         r_err   <= w_stuffErr | w_formErr;
         if (w_stuffErr) begin
            r_errCode <= ERR_STUFF;
         end else if (w_formErr) begin
            r_errCode <= ERR_FORM;
         end
         if (w_frameOk) begin
            r_outId   <= r_id;
            r_outDlc  <= r_dlc;
            r_outData <= r_data;
            r_outCrc  <= r_crcRx;
            r_crcErr  <= CRC_EN && (r_crcRx != w_crc);
         end
      end
   end

   can_crc15 u_crc (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (w_sof),
      .en     (w_crcEn),
      .bit_in (w_bit),
      .crc    (w_crc)
   );

   assign bus.busy        = (r_state != IDLE);
   assign bus.rx_valid    = r_valid;
   assign bus.rx_id       = r_outId;
   assign bus.rx_dlc      = r_outDlc;
   assign bus.rx_data     = r_outData;
   assign bus.rx_crc      = r_outCrc;
   assign bus.rx_crc_err  = r_crcErr;
   assign bus.rx_err      = r_err;
   assign bus.rx_err_code = r_errCode;

endmodule

// File: doc/can_rx.md
CAN_RX -- requirements
Module: can_rx

Interface
REQ-001 Parameter IDLE_BITS, 3, number of consecutive recessive bits required in WAIT_IDLE before a new SOF is accepted.
REQ-002 Parameter CRC_EN, 1, 1 = check CRC-15 and report mismatch; 0 = rx_crc_err tied 0.
REQ-003 clk  input  1  single clock; one CAN bit per clk cycle.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 rx  input  1  CAN bus line; 0 = dominant, 1 = recessive.
REQ-006 busy  output  1  high from SOF detection until return to IDLE.
REQ-007 rx_valid  output  1  one-cycle pulse; frame fields are valid.
REQ-008 rx_id  output  11  received identifier.
REQ-009 rx_dlc  output  4  raw received DLC.
REQ-010 rx_data  output  64  payload; byte k occupies [8k+7:8k], MSB received first.
REQ-011 rx_crc  output  15  received CRC field.
REQ-012 rx_crc_err  output  1  qualified by rx_valid; received CRC differs from computed CRC.
REQ-013 rx_err  output  1  one-cycle pulse on stuff or form error.
REQ-014 rx_err_code  output  2  qualified by rx_err: 01 = stuff, 10 = form.

Function
REQ-015 rx SHALL pass through a 2-flop synchronizer, reset to 1; all references to sampled bits below mean the synchronized bit.
REQ-016 The FSM SHALL have states IDLE, RECV, CRC_DELIM, WAIT_IDLE.
REQ-017 IDLE: a sampled 0 is the SOF. It SHALL set busy, load the stuff tracker with last=0 and count=1, and move to RECV.
REQ-018 RECV SHALL read fields in this order, MSB first: ID(11), RTR, IDE, r0, DLC(4), data (min(DLC,8)*8 bits), CRC(15).
REQ-019 DLC values 9..15 SHALL be treated as 8 data bytes; rx_dlc reports the raw value.
REQ-020 Destuffing SHALL apply from SOF through the last CRC bit. After 5 equal consecutive bits (stuff bits counted), the next bit is a stuff bit and is discarded. After a stuff bit, count=1 and last=the stuff bit value.
REQ-021 A stuff-position bit equal to the previous bit SHALL raise a stuff error.
REQ-022 When CRC_EN=1, CRC-15 (poly 0x4599, init 0) SHALL be computed serially over destuffed bits from SOF through the last data bit.
REQ-023 After the last CRC bit the FSM SHALL enter CRC_DELIM. No destuffing applies in CRC_DELIM. The sampled bit must be 1; a 0 raises a form error.
REQ-024 On a valid delimiter, rx_valid SHALL pulse in the next cycle together with all rx_* fields and rx_crc_err. The FSM then enters WAIT_IDLE.
REQ-025 rx_data bytes beyond the DLC SHALL read 0. All rx_* field outputs SHALL hold until the next rx_valid.
REQ-026 On any error: rx_err SHALL pulse one cycle, rx_valid SHALL NOT assert, and the FSM SHALL enter WAIT_IDLE.
REQ-027 WAIT_IDLE SHALL count consecutive 1s, restarting the count on any 0. At IDLE_BITS the FSM SHALL go to IDLE and clear busy.
REQ-028 Latency: rx_valid SHALL occur 3 clk after the delimiter bit is present on rx (2 synchronizer cycles + 1).
REQ-029 A 0 seen in IDLE in the same cycle that WAIT_IDLE exits SHALL NOT occur: IDLE is entered only after IDLE_BITS recessive bits.

Reset
REQ-030 rst_n low SHALL force IDLE and set synchronizer flops to 1. busy, rx_valid, rx_err, rx_crc_err SHALL be 0; rx_err_code=0; rx_id, rx_dlc, rx_data, rx_crc SHALL be 0.
REQ-031 Reset mid-frame SHALL abandon the frame with no rx_valid or rx_err. Reception resumes at the first SOF after release.

Structure
REQ-032 Package can_pkg SHALL hold: CRC15_POLY, field widths (ID_W=11, DLC_W=4, DATA_W=64, CRC_W=15), stuff limit 5, FSM state enum, and error-code constants.
REQ-033 The serial CRC SHALL be a sub-module can_crc15 (clk, rst_n, clear, en, bit_in, crc[14:0]), reusable by the transmitter.

Verification
REQ-034 Frame ID=0x123, DLC=2, data bytes 0xAB,0xCD, correct CRC -> one rx_valid; rx_id=0x123, rx_dlc=2, rx_data=64'h0000_0000_0000_CDAB, rx_crc_err=0.
REQ-035 Frame ID=0x000, DLC=0, with a stuff bit inserted after SOF plus the first 4 ID bits -> rx_valid; rx_id=0, no rx_err.
REQ-036 Six consecutive dominant bits inside the ID -> rx_err=1, rx_err_code=01, no rx_valid, busy holds until 3 recessive bits.
REQ-037 Correct frame with CRC delimiter driven 0 -> rx_err_code=10; same frame with CRC bit 0 flipped -> rx_valid with rx_crc_err=1.
REQ-038 DLC=8 data 64'h0123_4567_89AB_CDEF, then rst_n pulsed low mid-data -> outputs 0, no pulses; a following frame with ID=0x7FF is received correctly.
